// File: rtl/ysyx_22050598_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22050598_muldiv_unit_if
// Brief   : EX-stage <-> M-extension unit handshake, op controls and result.
// Revision: 1.0 - initial release
// ============================================================================
interface ysyx_22050598_muldiv_unit_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        is_mul;
    logic        is_div;
    logic        is_rem;
    logic        mul_high;
    logic        src1_signed;
    logic        src2_signed;
    logic        is_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        out_valid;
    logic [63:0] result;

    modport master (
        output flush, in_valid, is_mul, is_div, is_rem, mul_high,
               src1_signed, src2_signed, is_word, src1, src2,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, is_mul, is_div, is_rem, mul_high,
               src1_signed, src2_signed, is_word, src1, src2,
        output in_ready, out_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050598_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22050598_muldiv_unit
// Brief   : Iterative RV64M multiply/divide, one radix-2 step per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22050598_muldiv_unit (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    ysyx_22050598_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [6:0] c_iter_dw = 7'd64;
    localparam logic [6:0] c_iter_w  = 7'd32;

    state_t       r_state, w_state_nxt;
    logic [6:0]   r_cnt;
    logic         r_is_mul, r_is_rem, r_mul_high, r_is_word, r_neg, r_rneg;
    logic [127:0] r_acc, r_mcand;
    logic [63:0]  r_mplier, r_quot, r_rem, r_divisor, r_result;

    logic         w_op2_signed, w_s1, w_s2, w_div_zero, w_div_ovf, w_special, w_accept;
    logic [63:0]  w_op1_ext, w_op2_ext, w_mag1, w_mag2, w_dvd_res, w_special_res, w_min_neg;

    // Division takes the signedness of both operands from src1_signed.
    assign w_op2_signed  = bus.is_mul ? bus.src2_signed : bus.src1_signed;
    assign w_op1_ext     = bus.is_word ? {{32{bus.src1_signed & bus.src1[31]}}, bus.src1[31:0]} : bus.src1;
    assign w_op2_ext     = bus.is_word ? {{32{w_op2_signed & bus.src2[31]}}, bus.src2[31:0]} : bus.src2;
    assign w_s1          = bus.src1_signed & w_op1_ext[63];
    assign w_s2          = w_op2_signed & w_op2_ext[63];
    assign w_mag1        = w_s1 ? -w_op1_ext : w_op1_ext;
    assign w_mag2        = w_s2 ? -w_op2_ext : w_op2_ext;
    assign w_dvd_res     = bus.is_word ? {{32{bus.src1[31]}}, bus.src1[31:0]} : bus.src1;
    assign w_min_neg     = bus.is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign w_div_zero    = ~bus.is_mul & (w_op2_ext == 64'd0);
    assign w_div_ovf     = ~bus.is_mul & bus.src1_signed & (w_op2_ext == {64{1'b1}}) & (w_op1_ext == w_min_neg);
    assign w_special     = w_div_zero | w_div_ovf;
    assign w_special_res = w_div_zero ? (bus.is_rem ? w_dvd_res : {64{1'b1}})
                                      : (bus.is_rem ? 64'd0 : w_dvd_res);
    assign w_accept      = (r_state == S_IDLE) & bus.in_valid & ~bus.flush;

    logic [127:0] w_acc_nxt, w_prod;
    logic [64:0]  w_rem_sh;
    logic         w_ge;
    logic [63:0]  w_rem_nxt, w_quot_nxt, w_q, w_r, w_raw, w_final;

    assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_rem_sh   = {r_rem, r_quot[63]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_nxt  = w_ge ? (w_rem_sh[63:0] - r_divisor) : w_rem_sh[63:0];
    assign w_quot_nxt = {r_quot[62:0], w_ge};

    // Final result is formed from the last iteration's next values.
    assign w_prod  = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_q     = r_neg ? -w_quot_nxt : w_quot_nxt;
    assign w_r     = r_rneg ? -w_rem_nxt : w_rem_nxt;
    assign w_raw   = r_is_mul ? ((r_mul_high & ~r_is_word) ? w_prod[127:64] : w_prod[63:0])
                              : (r_is_rem ? w_r : w_q);
    assign w_final = r_is_word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 7'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 7'd0;
            r_is_mul   <= 1'b0;
            r_is_rem   <= 1'b0;
            r_mul_high <= 1'b0;
            r_is_word  <= 1'b0;
            r_neg      <= 1'b0;
            r_rneg     <= 1'b0;
            r_acc      <= 128'd0;
            r_mcand    <= 128'd0;
            r_mplier   <= 64'd0;
            r_quot     <= 64'd0;
            r_rem      <= 64'd0;
            r_divisor  <= 64'd0;
            r_result   <= 64'd0;
        end else if (w_accept) begin
            r_cnt      <= w_special ? 7'd0 : (bus.is_word ? c_iter_w : c_iter_dw);
            r_is_mul   <= bus.is_mul;
            r_is_rem   <= bus.is_rem;
            r_mul_high <= bus.mul_high;
            r_is_word  <= bus.is_word;
            r_neg      <= w_s1 ^ w_s2;
            r_rneg     <= w_s1;
            r_acc      <= 128'd0;
            r_mcand    <= {64'd0, w_mag1};
            r_mplier   <= w_mag2;
            // Word dividends sit in the top half so 32 shifts consume them.
            r_quot     <= bus.is_word ? {w_mag1[31:0], 32'd0} : w_mag1;
            r_rem      <= 64'd0;
            r_divisor  <= w_mag2;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == S_BUSY) begin
            if (bus.flush) begin
                r_cnt <= 7'd0;
            end else begin
                r_cnt    <= r_cnt - 7'd1;
                r_acc    <= w_acc_nxt;
                r_mcand  <= {r_mcand[126:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[63:1]};
                r_quot   <= w_quot_nxt;
                r_rem    <= w_rem_nxt;
                if (r_cnt == 7'd1) begin
                    r_result <= w_final;
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050598_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_22050598_muldiv_unit
// Brief   : Directed self-checking bench for the RV64M multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_22050598_muldiv_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    ysyx_22050598_muldiv_unit_if bus ();

    ysyx_22050598_muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // cls = {mul, div, rem}
    task automatic drive(input logic [2:0] cls, input logic hi, input logic s1, input logic s2,
                         input logic w, input logic [63:0] a, input logic [63:0] b);
        bus.is_mul      = cls[2];
        bus.is_div      = cls[1];
        bus.is_rem      = cls[0];
        bus.mul_high    = hi;
        bus.src1_signed = s1;
        bus.src2_signed = s2;
        bus.is_word     = w;
        bus.src1        = a;
        bus.src2        = b;
    endtask

    task automatic quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < n; c++) begin
            if (bus.out_valid === 1'b1) seen++;
            tick();
        end
        check(tag, seen, 0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] cls, input logic hi, input logic s1,
                         input logic s2, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat);
        int got;
        int rdy_hi;
        check({tag, ".ready_in"}, bus.in_ready, 1'b1);
        drive(cls, hi, s1, s2, w, a, b);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        got    = -1;
        rdy_hi = 0;
        for (int c = 1; c <= 80; c++) begin
            if (bus.in_ready === 1'b1) rdy_hi++;
            if (bus.out_valid === 1'b1) begin
                got = c;
                break;
            end
            tick();
        end
        check({tag, ".latency"}, got, lat);
        check({tag, ".result"}, bus.result, exp);
        check({tag, ".busy_ready"}, rdy_hi, 0);
        tick();
        check({tag, ".valid_drop"}, bus.out_valid, 1'b0);
        check({tag, ".idle_next"}, bus.in_ready, 1'b1);
        check({tag, ".hold"}, bus.result, exp);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) tick();
        check("rst.ready", bus.in_ready, 1'b1);
        check("rst.valid", bus.out_valid, 1'b0);
        check("rst.result", bus.result, 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst.ready", bus.in_ready, 1'b1);

        // Multiply family
        do_op("mul_3x5", 3'b100, 0, 1, 1, 0, 64'd3, 64'd5, 64'd15, 65);
        do_op("mulh_m1", 3'b100, 1, 1, 1, 0, {64{1'b1}}, {64{1'b1}}, 64'd0, 65);
        do_op("mulhu_m1", 3'b100, 1, 0, 0, 0, {64{1'b1}}, {64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        do_op("mulhsu", 3'b100, 1, 1, 0, 0, {64{1'b1}}, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        do_op("mulw", 3'b100, 0, 1, 1, 1, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        do_op("mul_neg", 3'b100, 0, 1, 1, 0, -64'sd6, 64'd7, -64'sd42, 65);

        // Divide special cases
        do_op("divw_by0", 3'b010, 0, 1, 1, 1, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op("remw_by0", 3'b001, 0, 1, 1, 1, 64'd7, 64'd0, 64'd7, 1);
        do_op("div_ovf", 3'b010, 0, 1, 1, 0, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000, 1);
        do_op("rem_ovf", 3'b001, 0, 1, 1, 0, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'd0, 1);
        do_op("divw_ovf", 3'b010, 0, 1, 1, 1, 64'h0000_0000_8000_0000, {64{1'b1}}, 64'hFFFF_FFFF_8000_0000, 1);

        // Regular divides
        do_op("divu", 3'b010, 0, 0, 0, 0, 64'd100, 64'd7, 64'd14, 65);
        do_op("remu", 3'b001, 0, 0, 0, 0, 64'd100, 64'd7, 64'd2, 65);
        do_op("divuw", 3'b010, 0, 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        do_op("remw_neg", 3'b001, 0, 1, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);

        // Flush at T+10 aborts the op
        drive(3'b001, 0, 0, 0, 0, 64'd7, 64'd3);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        quiet("flush.pre", 9);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush.idle", bus.in_ready, 1'b1);
        quiet("flush.no_valid", 70);
        do_op("remu_reissue", 3'b001, 0, 0, 0, 0, 64'd7, 64'd3, 64'd1, 65);

        // Flush and in_valid together in IDLE: no accept
        drive(3'b100, 0, 0, 0, 0, 64'd9, 64'd9);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_accept.ready", bus.in_ready, 1'b1);
        quiet("flush_accept.no_valid", 70);

        // Reset mid-BUSY discards the op
        drive(3'b010, 0, 1, 1, 0, -64'sd7, 64'd2);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        check("midrst.ready", bus.in_ready, 1'b1);
        check("midrst.valid", bus.out_valid, 1'b0);
        check("midrst.result", bus.result, 64'd0);
        tick();
        rst_n = 1'b1;
        quiet("midrst.no_valid", 70);
        do_op("div_m7_2", 3'b010, 0, 1, 1, 0, -64'sd7, 64'd2, -64'sd3, 65);
        do_op("rem_m7_2", 3'b001, 0, 1, 1, 0, -64'sd7, 64'd2, -64'sd1, 65);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
